// File: rtl/bus_pkg.sv
// Shared response encoding for the simple valid/ready bus.
package bus_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b10
   } resp_t;

endpackage

// File: rtl/bus_slave_mem_if.sv
// Single-transfer valid/ready bus between an initiator and a slave endpoint.
interface bus_slave_mem_if #(
   parameter int DATA_W = 8
);

   logic                valid;
   logic                wr_en;
   logic [7:0]          addr;
   logic [DATA_W-1:0]   wdata;
   logic                ready;
   logic [DATA_W-1:0]   rdata;
   bus_pkg::resp_t      resp;

   modport master (
      output valid, wr_en, addr, wdata,
      input  ready, rdata, resp
   );

   modport slave (
      input  valid, wr_en, addr, wdata,
      output ready, rdata, resp
   );

endinterface

// File: rtl/bus_slave_mem.sv
// Memory-backed bus responder with programmable wait states; out-of-range
// addresses complete with RESP_ERROR and leave storage untouched.
module bus_slave_mem #(
   parameter logic [7:0] BASE_ADDR   = 8'h00,
   parameter int         DEPTH       = 16,
   parameter int         DATA_W      = 8,
   parameter int         WAIT_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst,
   bus_slave_mem_if.slave bus
);

   import bus_pkg::*;

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
      $error("bus_slave_mem: DEPTH must be within 1..64");
   end
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("bus_slave_mem: WAIT_CYCLES must be within 0..15");
   end
   if (int'(BASE_ADDR) + DEPTH > 256) begin : g_bad_window
      $error("bus_slave_mem: BASE_ADDR + DEPTH exceeds the 8-bit address space");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_wr;
   logic                r_hit;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_ready;
   logic [DATA_W-1:0]   r_rdata;
   resp_t               r_resp;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [7:0]          w_off_in;
   logic                w_hit_in;
   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_sel_hit;
   logic                w_sel_wr;
   logic                w_go_resp;

   // Offset is only meaningful when addr >= BASE_ADDR, so the subtraction never wraps on a hit.
   assign w_off_in = bus.addr - BASE_ADDR;
   assign w_hit_in = (bus.addr >= BASE_ADDR) && ({1'b0, w_off_in} < 9'(DEPTH));

   // With zero wait states the response is built straight from the bus inputs.
   always_comb begin
      w_sel_idx = r_idx;
      w_sel_hit = r_hit;
      w_sel_wr  = r_wr;
      if (r_state == ST_IDLE) begin
         w_sel_idx = w_off_in[IDX_W-1:0];
         w_sel_hit = w_hit_in;
         w_sel_wr  = bus.wr_en;
      end
   end

   always_comb begin
      w_go_resp = 1'b0;
      case (r_state)
         ST_IDLE: w_go_resp = bus.valid && (WAIT_CYCLES == 0);
         ST_WAIT: w_go_resp = bus.valid && (r_cnt == 4'd0);
         default: w_go_resp = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_wr    <= 1'b0;
         r_hit   <= 1'b0;
         r_wdata <= '0;
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_resp  <= RESP_OKAY;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_resp  <= RESP_OKAY;

         case (r_state)
            ST_IDLE: begin
               if (bus.valid) begin
                  r_idx   <= w_off_in[IDX_W-1:0];
                  r_wr    <= bus.wr_en;
                  r_hit   <= w_hit_in;
                  r_wdata <= bus.wdata;
                  if (WAIT_CYCLES == 0) begin
                     r_state <= ST_RESP;
                  end else begin
                     r_cnt   <= 4'(WAIT_CYCLES - 1);
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!bus.valid) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (r_wr && r_hit) begin
                  r_mem[r_idx] <= r_wdata;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         // Read data is sampled on the edge that enters RESP, before any write lands.
         if (w_go_resp) begin
            r_ready <= 1'b1;
            r_resp  <= w_sel_hit ? RESP_OKAY : RESP_ERROR;
            if (w_sel_hit && !w_sel_wr) begin
               r_rdata <= r_mem[w_sel_idx];
            end
         end
      end
   end

   assign bus.ready = r_ready;
   assign bus.rdata = r_rdata;
   assign bus.resp  = r_resp;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed and randomized bench for bus_slave_mem across four parameterisations.
module tb_bus_slave_mem;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NI-1:0] tv;
   logic [NI-1:0] twr;
   logic [7:0]    ta  [NI];
   logic [7:0]    twd [NI];
   logic [NI-1:0] o_rdy;
   logic [7:0]    o_rd [NI];
   logic [1:0]    o_rs [NI];

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mm [NI][256];

   function automatic int base_of(int k);
      return (k == 2) ? 8'h40 : 0;
   endfunction
   function automatic int depth_of(int k);
      return (k == 2) ? 8 : 16;
   endfunction
   function automatic int wait_of(int k);
      case (k)
         0: return 2;
         1: return 0;
         2: return 15;
         default: return 3;
      endcase
   endfunction
   function automatic bit hit_of(int k, logic [7:0] a);
      int ai = int'(a);
      return (ai >= base_of(k)) && (ai - base_of(k) < depth_of(k));
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      bus_slave_mem_if #(.DATA_W(8)) bif ();
      assign bif.valid = tv[g];
      assign bif.wr_en = twr[g];
      assign bif.addr  = ta[g];
      assign bif.wdata = twd[g];
      assign o_rdy[g]  = bif.ready;
      assign o_rd[g]   = bif.rdata;
      assign o_rs[g]   = bif.resp;

      bus_slave_mem #(
         .BASE_ADDR   ((g == 2) ? 8'h40 : 8'h00),
         .DEPTH       ((g == 2) ? 8 : 16),
         .DATA_W      (8),
         .WAIT_CYCLES ((g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 15 : 3)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bif)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 256; a++)
            mm[k][a] = 8'h00;
   endtask

   // Called at a negedge; that cycle is cycle 0 of the transfer.
   task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rdata, output logic [1:0] resp);
      tv[k] = 1'b1; twr[k] = wr; ta[k] = a; twd[k] = d;
      lat = -1; rdata = 8'hxx; resp = 2'bxx;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (o_rdy[k]) begin
            lat = c; rdata = o_rd[k]; resp = o_rs[k];
            break;
         end
      end
      tv[k] = 1'b0;
   endtask

   task automatic check_xfer(input string tag, input int k, input bit wr,
                             input logic [7:0] a, input logic [7:0] d);
      int lat;
      logic [7:0] rd;
      logic [1:0] rs;
      bit h = hit_of(k, a);
      logic [7:0] exp_rd = (!wr && h) ? mm[k][a] : 8'h00;
      logic [1:0] exp_rs = h ? bus_pkg::RESP_OKAY : bus_pkg::RESP_ERROR;
      xfer(k, wr, a, d, lat, rd, rs);
      chk({tag, "_lat"}, lat, wait_of(k) + 1);
      chk({tag, "_resp"}, rs, exp_rs);
      chk({tag, "_rdata"}, rd, exp_rd);
      if (wr && h) mm[k][a] = d;
      @(negedge clk);
      chk({tag, "_pulse"}, {o_rdy[k], o_rd[k], o_rs[k]}, {1'b0, 8'h00, bus_pkg::RESP_OKAY});
   endtask

   initial begin
      int lat;
      logic [7:0] rd;
      logic [1:0] rs;
      bit seen;

      tv = '0; twr = '0;
      for (int k = 0; k < NI; k++) begin ta[k] = 8'h00; twd[k] = 8'h00; end
      clear_model();

      @(negedge clk);
      for (int k = 0; k < NI; k++)
         chk($sformatf("reset_out%0d", k), {o_rdy[k], o_rd[k], o_rs[k]},
             {1'b0, 8'h00, bus_pkg::RESP_OKAY});
      rst = 1'b0;
      @(negedge clk);

      // Reset during WAIT aborts the write.
      tv[0] = 1'b1; twr[0] = 1'b1; ta[0] = 8'h03; twd[0] = 8'h5A;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_ready", o_rdy[0], 1'b0);
      @(negedge clk);
      chk("rst_hold_ready", o_rdy[0], 1'b0);
      rst = 1'b0; tv[0] = 1'b0;
      clear_model();
      repeat (4) begin
         @(negedge clk);
         chk("rst_after_ready", o_rdy[0], 1'b0);
      end
      check_xfer("rst_read03", 0, 1'b0, 8'h03, 8'h00);

      // Write/read, two wait states.
      check_xfer("wr05", 0, 1'b1, 8'h05, 8'hA5);
      check_xfer("rd05", 0, 1'b0, 8'h05, 8'h00);
      chk("rd05_model", mm[0][5], 8'hA5);

      // Out of range and boundaries.
      check_xfer("oor_wr10", 0, 1'b1, 8'h10, 8'hFF);
      check_xfer("oor_rd00", 0, 1'b0, 8'h00, 8'h00);
      check_xfer("bnd_wr0f", 0, 1'b1, 8'h0F, 8'h3C);
      check_xfer("bnd_wr00", 0, 1'b1, 8'h00, 8'hC3);
      check_xfer("bnd_rd0f", 0, 1'b0, 8'h0F, 8'h00);
      check_xfer("bnd_rd00", 0, 1'b0, 8'h00, 8'h00);

      // Zero wait states, then back-to-back with valid held.
      check_xfer("z_rd00", 1, 1'b0, 8'h00, 8'h00);
      tv[1] = 1'b1; twr[1] = 1'b1; ta[1] = 8'h07; twd[1] = 8'h11;
      @(negedge clk);
      chk("b2b_first", {o_rdy[1], o_rs[1]}, {1'b1, bus_pkg::RESP_OKAY});
      twr[1] = 1'b0; twd[1] = 8'hEE;
      @(negedge clk);
      chk("b2b_gap", o_rdy[1], 1'b0);
      @(negedge clk);
      chk("b2b_second", {o_rdy[1], o_rd[1], o_rs[1]}, {1'b1, 8'h11, bus_pkg::RESP_OKAY});
      tv[1] = 1'b0;
      mm[1][7] = 8'h11;
      @(negedge clk);

      // Offset window and maximum wait states.
      check_xfer("b40_rd3f", 2, 1'b0, 8'h3F, 8'h00);
      check_xfer("b40_wr47", 2, 1'b1, 8'h47, 8'h9D);
      check_xfer("b40_rd47", 2, 1'b0, 8'h47, 8'h00);
      check_xfer("b40_wr48", 2, 1'b1, 8'h48, 8'h12);

      // Abort by dropping valid in cycle 1.
      check_xfer("ab_pre", 3, 1'b1, 8'h09, 8'h42);
      tv[3] = 1'b1; twr[3] = 1'b1; ta[3] = 8'h09; twd[3] = 8'h77;
      @(negedge clk);
      tv[3] = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (o_rdy[3]) seen = 1'b1;
      end
      chk("ab_no_ready", seen, 1'b0);
      check_xfer("ab_rd09", 3, 1'b0, 8'h09, 8'h00);
      check_xfer("ab_next_wr", 3, 1'b1, 8'h0A, 8'h5E);
      check_xfer("ab_next_rd", 3, 1'b0, 8'h0A, 8'h00);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 120; n++) begin
         int k = int'($urandom_range(0, NI - 1));
         logic [7:0] a;
         bit wr = bit'($urandom_range(0, 1));
         logic [7:0] d = 8'($urandom);
         if (k == 2) a = 8'($urandom_range(8'h3C, 8'h4A));
         else        a = 8'($urandom_range(0, 8'h13));
         check_xfer($sformatf("rnd%0d_k%0d_a%0h", n, k, a), k, wr, a, d);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Leftover content sweep for the main instance.
      for (int a = 0; a < 16; a++)
         check_xfer($sformatf("sweep_%0h", a), 0, 1'b0, 8'(a), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
